// File: rtl/cordic_arb_pkg.sv
// cordic_arb_pkg: shared types and defaults for the cordic_vec arbiter.
package cordic_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} arb_state_t;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_TIMEOUT = 255;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotate-and-priority-encode round-robin grant starting just after ptr.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] c;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    c = '0;
    for (int k = 1; k <= N; k++) begin
      c = IW'((int'(ptr) + k) % N);
      if (en && !found && req[c]) begin
        found = 1'b1;
        gnt[c] = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/cordic_vec_arbiter.sv
// cordic_vec_arbiter: round-robin sharing of one cordic_vec engine among N_REQ requesters,
// with a watchdog that aborts a job whose engine never reports done.
module cordic_vec_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ID_W = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_phase,
  output logic [WIDTH-1:0]       rsp_magnitude,
  output logic                   rsp_err,
  output logic                   cv_start,
  output logic [WIDTH-1:0]       cv_in_x,
  output logic [WIDTH-1:0]       cv_in_y,
  input  logic                   cv_ready,
  input  logic                   cv_done,
  input  logic [WIDTH-1:0]       cv_phase,
  input  logic [WIDTH-1:0]       cv_magnitude,
  output logic                   timeout_sticky
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  arb_state_t state_q;
  logic [ID_W-1:0] ptr_q, id_q, g_idx;
  logic [N_REQ-1:0] g_hot;
  logic [WD_W-1:0] wd_q;
  logic [WIDTH-1:0] x_q, y_q, phase_q, mag_q;
  logic start_q, valid_q, err_q, sticky_q, en;
  assign en = (state_q == IDLE) && cv_ready;
  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_rr (
    .req(req_valid),
    .ptr(ptr_q),
    .en(en),
    .gnt(g_hot),
    .idx(g_idx)
  );
  assign req_ready = g_hot;
  assign cv_start = start_q;
  assign cv_in_x = x_q;
  assign cv_in_y = y_q;
  assign rsp_valid = valid_q;
  assign rsp_id = id_q;
  assign rsp_phase = phase_q;
  assign rsp_magnitude = mag_q;
  assign rsp_err = err_q;
  assign timeout_sticky = sticky_q;
  // cv_done is checked before the watchdog so a result arriving on the expiry cycle is kept
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= ID_W'(N_REQ - 1);
      id_q <= '0;
      wd_q <= '0;
      x_q <= '0;
      y_q <= '0;
      phase_q <= '0;
      mag_q <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|g_hot) begin
          x_q <= req_x[g_idx*WIDTH +: WIDTH];
          y_q <= req_y[g_idx*WIDTH +: WIDTH];
          id_q <= g_idx;
          ptr_q <= g_idx;
          wd_q <= '0;
          start_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: if (cv_done) begin
          phase_q <= cv_phase;
          mag_q <= cv_magnitude;
          err_q <= 1'b0;
          start_q <= 1'b0;
          state_q <= DRAIN;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          phase_q <= '0;
          mag_q <= '0;
          err_q <= 1'b1;
          sticky_q <= 1'b1;
          start_q <= 1'b0;
          state_q <= DRAIN;
        end else begin
          wd_q <= wd_q + WD_W'(1);
        end
        DRAIN: if (!cv_done) begin
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (rsp_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cordic_vec_arbiter.md
Name: cordic_vec_arbiter

Overview:
Shares a single cordic_vec engine among N_REQ independent requesters using round-robin arbitration. Each requester issues an (x, y) vectoring job through a valid/ready handshake. The arbiter sequences the engine's start/done protocol and returns phase and magnitude tagged with the requester ID on one response channel. It also guards against a hung engine with a watchdog timeout.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 32, operand and result width; must match the engine
ID_W, $clog2(N_REQ), response ID width
TIMEOUT_CYCLES, 255, max cycles in ISSUE waiting for cv_done before aborting

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high
req_valid  in  N_REQ  per-requester job valid
req_ready  out  N_REQ  one-hot grant/accept pulse
req_x  in  N_REQ*WIDTH  packed x operands; requester i at [i*WIDTH +: WIDTH]
req_y  in  N_REQ*WIDTH  packed y operands; same packing as req_x
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  requester that owns the response
rsp_phase  out  WIDTH  engine phase result
rsp_magnitude  out  WIDTH  engine magnitude result
rsp_err  out  1  response aborted by timeout
cv_start  out  1  engine start
cv_in_x  out  WIDTH  engine x operand
cv_in_y  out  WIDTH  engine y operand
cv_ready  in  1  engine idle
cv_done  in  1  engine result valid
cv_phase  in  WIDTH  engine phase
cv_magnitude  in  WIDTH  engine magnitude
timeout_sticky  out  1  set on any timeout; cleared only by reset

Behaviour:
- Reset: state IDLE. All outputs 0. Round-robin pointer set to N_REQ-1, so requester 0 has top priority first. Watchdog counter 0.
- Engine protocol: cv_start is held high until cv_done is seen high. Results are valid while cv_done=1. The next job is not issued until cv_done returns low.
- IDLE: if cv_ready=1 and any req_valid, grant the first requester at or after pointer+1 (mod N_REQ).
  - Assert req_ready[g] for exactly that cycle.
  - Latch req_x/req_y slice g into cv_in_x/cv_in_y, and g into the ID register.
  - Pointer <= g. Next state ISSUE.
  - If no req_valid or cv_ready=0, stay in IDLE with req_ready=0.
- ISSUE: cv_start=1; cv_in_x/cv_in_y stable; watchdog increments each cycle.
  - On cv_done=1: capture cv_phase/cv_magnitude, rsp_err<=0, cv_start<=0, go to DRAIN.
  - If the watchdog reaches TIMEOUT_CYCLES first: cv_start<=0, results<=0, rsp_err<=1, timeout_sticky<=1, go to DRAIN.
- DRAIN: cv_start=0. When cv_done=0, go to RESP.
- RESP: rsp_valid=1 with rsp_id/rsp_phase/rsp_magnitude/rsp_err stable. On rsp_valid&&rsp_ready, drop rsp_valid next cycle and go to IDLE.
- Latency:
  - Grant at cycle T gives cv_start=1 at T+1.
  - cv_done first seen high at D gives cv_start=0 at D+1.
  - cv_done low at L gives rsp_valid=1 at L+1.
- Single job outstanding. req_ready is never asserted outside IDLE. At most one req_ready bit is high in any cycle.
- req_valid drop before grant: the job is silently ignored (no retention); requesters should hold valid until ready.
- Simultaneous requests: strictly round-robin. Every requester with continuous valid is served within N_REQ grants.
- cv_done arriving on the same cycle the watchdog expires: cv_done wins, and the result is captured with no error.
- Reset mid-operation: next edge returns to IDLE and all outputs go to 0. The engine shares the reset, so there is no drain.
- Outputs are registered. No combinational path from req_valid to cv_*. req_ready is combinational from state, pointer, cv_ready and req_valid.

Decomposition:
- Package cordic_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, DRAIN, RESP}
  - DEFAULT_WIDTH=32
  - DEFAULT_TIMEOUT=255
- Sub-module rr_arbiter (parameter N):
  - Inputs req[N], ptr, en.
  - Outputs one-hot grant and encoded index.
  - Rotate-and-priority-encode logic; pointer update is owned by the parent.
- Bench uses a behavioural cordic_vec stub:
  - Programmable latency.
  - Returns phase = x+y, magnitude = x^y.
  - Holds cv_done high for 2 cycles.

Test Plan:
- Reset, then requester 0 sends x=32'h4000_0000, y=0. Expect req_ready=4'b0001, and cv_start high one cycle later. With 34-cycle stub latency: rsp_id=0, rsp_phase=32'h4000_0000, rsp_magnitude=32'h4000_0000, rsp_err=0.
- All 4 requesters valid continuously, 8 jobs. Expect grant order 0,1,2,3,0,1,2,3. rsp_id matches order, and each result matches its own operands.
- Requesters 1 and 3 only, with pointer at 1. Expect grant order 3,1,3. Requesters 0 and 2 never get req_ready.
- Stub never asserts done. Expect cv_start to drop after 255 ISSUE cycles, then rsp_valid with rsp_err=1, phase=0, magnitude=0, and timeout_sticky=1. The next job completes normally with rsp_err=0.
- rsp_ready held low for 20 cycles while requester 2 is valid. Expect rsp_valid and the data held stable, and req_ready[2] to stay 0 until the handshake completes.
- Assert reset during ISSUE. Next cycle: cv_start=0, rsp_valid=0, timeout_sticky=0. The first grant after reset goes to requester 0.
